// File: rtl/misr_pkg.sv
// Shared types and helpers for the MISR signature sequencer.
// The UNLOAD state is only reachable in builds with MISR_SCAN_EN defined.
package misr_pkg;

  localparam int MISR_W = 32;
  localparam logic [MISR_W-1:0] DEF_POLY = 32'h0000_8409;
  localparam logic [MISR_W-1:0] DEF_SEED = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_DONE,
    ST_UNLOAD
  } state_e;

  // One compaction step: shift left, fold the MSB back through the poly, add data.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                  input logic [MISR_W-1:0] data,
                                                  input logic [MISR_W-1:0] poly);
    return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0) ^ data;
  endfunction

endpackage

// File: rtl/misr_sig_reg.sv
// Signature register: load seed, compact one word, or shift left for serial unload.
// Priority is load > step > shift.
module misr_sig_reg
  import misr_pkg::*;
#(
  parameter int               WIDTH = MISR_W,
  parameter logic [WIDTH-1:0] POLY  = DEF_POLY,
  parameter logic [WIDTH-1:0] SEED  = DEF_SEED
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             load,
  input  logic             step,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load)       sig_d = SEED;
    else if (step)  sig_d = misr_step(sig_q, data, POLY);
    else if (shift) sig_d = {sig_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) sig_q <= SEED;
    else      sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/misr_sig_ctrl.sv
// MISR sequencer: seed, compact cfg_len words over valid/ready, compare with golden.
// Define MISR_SCAN_EN to add a post-run MSB-first serial unload on scan_out.
module misr_sig_ctrl
  import misr_pkg::*;
#(
  parameter int               WIDTH = MISR_W,
  parameter logic [WIDTH-1:0] POLY  = DEF_POLY,
  parameter logic [WIDTH-1:0] SEED  = DEF_SEED,
  parameter int               CNT_W = 16
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [WIDTH-1:0] golden,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig_out,
  output logic             scan_out
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [WIDTH-1:0] golden_q, golden_d;
  logic             pass_q, pass_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic             sig_load, sig_step, sig_shift;
  logic [WIDTH-1:0] sig;

`ifdef MISR_SCAN_EN
  localparam int             UW    = $clog2(WIDTH);
  localparam logic [UW-1:0]  ULAST = UW'(WIDTH - 1);
  logic [UW-1:0] ucnt_q, ucnt_d;
  logic          scan_q, scan_d;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    golden_d  = golden_q;
    pass_d    = pass_q;
    sig_load  = 1'b0;
    sig_step  = 1'b0;
    sig_shift = 1'b0;
`ifdef MISR_SCAN_EN
    ucnt_d    = ucnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // start outranks a same-cycle abort here
        if (start) begin
          len_d    = cfg_len;
          golden_d = golden;
          cnt_d    = '0;
          pass_d   = 1'b0;
          sig_load = 1'b1;
          state_d  = (cfg_len == '0) ? ST_CHECK : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (data_valid && ready_q) begin
          sig_step = 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc == len_q) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          pass_d  = (sig == golden_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef MISR_SCAN_EN
        ucnt_d  = '0;
        state_d = ST_UNLOAD;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef MISR_SCAN_EN
      ST_UNLOAD: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          sig_shift = 1'b1;
          ucnt_d    = ucnt_q + 1'b1;
          if (ucnt_q == ULAST) state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered off the next state so they line up with it.
    ready_d = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
`ifdef MISR_SCAN_EN
    // Register lags the shift by one cycle, so read one bit below the MSB once unloading.
    scan_d = 1'b0;
    if (state_d == ST_UNLOAD)
      scan_d = (state_q == ST_UNLOAD) ? sig[WIDTH-2] : sig[WIDTH-1];
`endif
  end

  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MISR_SCAN_EN
      ucnt_q   <= '0;
      scan_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      golden_q <= golden_d;
      pass_q   <= pass_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MISR_SCAN_EN
      ucnt_q   <= ucnt_d;
      scan_q   <= scan_d;
`endif
    end
  end

  misr_sig_reg #(
    .WIDTH(WIDTH),
    .POLY (POLY),
    .SEED (SEED)
  ) u_sig (
    .gclk (CK),
    .grst (RESET),
    .load (sig_load),
    .step (sig_step),
    .shift(sig_shift),
    .data (data_in),
    .sig  (sig)
  );

  assign data_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign sig_out    = sig;
`ifdef MISR_SCAN_EN
  assign scan_out   = scan_q;
`else
  assign scan_out   = 1'b0;
`endif

endmodule

// File: tb/tb_misr_sig_ctrl.sv
// Bench for misr_sig_ctrl: directed table, random runs against a word-queue model,
// plus abort, mid-run reset and (with MISR_SCAN_EN) serial unload checks.
module tb_misr_sig_ctrl;

  localparam logic [31:0] POLY = 32'h0000_8409;
  localparam logic [31:0] SEED = 32'h0000_0000;

  logic        CK = 1'b0, RESET = 1'b1;
  logic        start = 1'b0, abort = 1'b0, data_valid = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [31:0] golden = '0, data_in = '0;
  logic        data_ready, busy, done, pass, scan_out;
  logic [31:0] sig_out;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] words[$];

  always #5 CK = ~CK;

  misr_sig_ctrl dut (
    .CK(CK), .RESET(RESET), .start(start), .abort(abort), .cfg_len(cfg_len),
    .golden(golden), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .done(done), .pass(pass),
    .sig_out(sig_out), .scan_out(scan_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Signature of the first n queued words: multiply by x mod the feedback poly, add word.
  function automatic logic [31:0] ref_fold(input int n);
    logic [31:0] s = SEED;
    for (int i = 0; i < n; i++) begin
      logic carry = s[31];
      s = (s << 1) ^ words[i];
      if (carry) s = s ^ POLY;
    end
    return s;
  endfunction

  // vmode: 0 valid every cycle, 1 gap pattern then valid, 2 random valid with stray starts
  task automatic run_one(input string tag, input int len, input logic [31:0] gold,
                         input logic [31:0] exp_sig, input bit exp_pass,
                         input int vmode, input bit abort_at_start);
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int beats = 0, last_c = 0, pidx = 0, c;
    bit got_done = 0;
    @(negedge CK);
    start = 1; abort = abort_at_start; cfg_len = 16'(len); golden = gold; data_valid = 0;
    for (c = 1; c <= 400; c++) begin
      @(negedge CK);
      start = 0; abort = 0;
      if (c == 1) chk({tag, " busy_after_start"}, busy, 1);
      if (done) begin got_done = 1; break; end
      chk({tag, " ready"}, data_ready, beats < len);
      chk({tag, " sig_mid"}, sig_out, ref_fold(beats));
      case (vmode)
        0: data_valid = 1;
        1: begin data_valid = (pidx < 7) ? (pat[pidx] != 0) : 1'b1; pidx++; end
        default: data_valid = ($urandom_range(0, 9) < 7);
      endcase
      data_in = (beats < len) ? words[beats] : $urandom;
      if (vmode == 2 && $urandom_range(0, 3) == 0) begin
        start = 1; cfg_len = 16'($urandom); golden = $urandom;
      end
      if (beats < len && data_valid) begin beats++; last_c = c; end
    end
    data_valid = 0; start = 0;
    if (!got_done) begin
      chk({tag, " timeout_no_done"}, 0, 1);
      return;
    end
    chk({tag, " done_latency"}, c, last_c + 2);
    chk({tag, " beats"}, beats, len);
    chk({tag, " sig_final"}, sig_out, exp_sig);
    chk({tag, " pass"}, pass, exp_pass);
`ifdef MISR_SCAN_EN
    for (int k = 0; k < 32; k++) begin
      @(negedge CK);
      chk({tag, " unload_busy"}, busy, 1);
      chk({tag, " unload_done"}, done, 0);
      chk({tag, " scan_bit"}, scan_out, exp_sig[31-k]);
    end
`else
    chk({tag, " scan_tied"}, scan_out, 0);
`endif
    @(negedge CK);
    chk({tag, " idle_busy"}, busy, 0);
    chk({tag, " idle_done"}, done, 0);
    chk({tag, " pass_held"}, pass, exp_pass);
  endtask

  typedef struct {
    string       name;
    int          len;
    logic [31:0] gold, d0, d1, exp_sig;
    bit          exp_pass, abort_at_start;
  } vec_t;

  initial begin
    vec_t tbl[5];
    tbl[0] = '{"t1_basic",    2, 32'h3, 32'h1, 32'h1, 32'h3, 1'b1, 1'b0};
    tbl[1] = '{"t2_feedback", 2, 32'h0, 32'h8000_0000, 32'h0, 32'h0000_8409, 1'b0, 1'b0};
    tbl[2] = '{"t3_len0_ok",  0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    tbl[3] = '{"t3_len0_bad", 0, 32'h5, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[4] = '{"start_abort", 2, 32'h3, 32'h1, 32'h1, 32'h3, 1'b1, 1'b1};

    repeat (2) @(negedge CK);
    chk("rst busy", busy, 0);
    chk("rst ready", data_ready, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst sig", sig_out, SEED);
    chk("rst scan", scan_out, 0);
    RESET = 0;

    foreach (tbl[i]) begin
      words.delete();
      words.push_back(tbl[i].d0);
      words.push_back(tbl[i].d1);
      run_one(tbl[i].name, tbl[i].len, tbl[i].gold, tbl[i].exp_sig, tbl[i].exp_pass, 0,
              tbl[i].abort_at_start);
    end

    // Valid gaps: four beats land on pattern slots 0,3,4,6; later valids are ignored.
    words.delete();
    for (int i = 0; i < 4; i++) words.push_back($urandom);
    run_one("t4_gaps", 4, ref_fold(4), ref_fold(4), 1'b1, 1, 1'b0);

    for (int r = 0; r < 12; r++) begin
      int len = $urandom_range(0, 10);
      logic [31:0] exp, gold;
      words.delete();
      for (int i = 0; i < len; i++) words.push_back($urandom);
      exp  = ref_fold(len);
      gold = $urandom_range(0, 1) ? exp : exp ^ (32'h1 << $urandom_range(0, 31));
      run_one($sformatf("rand%0d", r), len, gold, exp, gold == exp, 2, 1'b0);
    end

    // Abort on the third beat: that word must not be compacted and no done follows.
    words.delete();
    for (int i = 0; i < 5; i++) words.push_back($urandom | 32'h1);
    @(negedge CK); start = 1; cfg_len = 16'd5; golden = 32'h0;
    @(negedge CK); start = 0; data_valid = 1; data_in = words[0];
    @(negedge CK); data_in = words[1];
    @(negedge CK); data_in = words[2]; abort = 1;
    chk("abort pre_sig", sig_out, ref_fold(2));
    @(negedge CK); abort = 0; data_valid = 0;
    chk("abort busy", busy, 0);
    chk("abort ready", data_ready, 0);
    chk("abort pass", pass, 0);
    chk("abort sig_kept", sig_out, ref_fold(2));
    for (int k = 0; k < 4; k++) begin
      @(negedge CK);
      chk("abort no_done", done, 0);
    end

    // Reset mid-run must clear everything before the next clock edge.
    words.delete();
    words.push_back(32'h1234_5678);
    words.push_back(32'h9abc_def0);
    @(negedge CK); start = 1; cfg_len = 16'd5; golden = 32'h0;
    @(negedge CK); start = 0; data_valid = 1; data_in = words[0];
    @(negedge CK); data_in = words[1];
    @(negedge CK); data_valid = 0;
    chk("rstmid pre_sig", sig_out, ref_fold(2));
    chk("rstmid pre_busy", busy, 1);
    #2 RESET = 1;
    #1;
    chk("rstmid busy", busy, 0);
    chk("rstmid ready", data_ready, 0);
    chk("rstmid done", done, 0);
    chk("rstmid pass", pass, 0);
    chk("rstmid sig", sig_out, SEED);
    chk("rstmid scan", scan_out, 0);
    @(negedge CK); RESET = 0;
    @(negedge CK);
    chk("rstmid idle", busy, 0);

`ifdef MISR_SCAN_EN
    words.delete();
    words.push_back(32'hA000_0001);
    run_one("t6_scan", 1, 32'hA000_0001, 32'hA000_0001, 1'b1, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
